// File: rtl/symser_pkg.sv
// Shared types and sizing helpers for the symbol serializer and related Zigbee TX stages.
package symser_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int SYM_W_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    LASTSYM = 2'd2
  } serState_e;

  function automatic int symCount(input int dataW, input int symW);
    return dataW / symW;
  endfunction

endpackage

// File: rtl/symbol_pick.sv
// Combinational selection of one SYM_W-wide symbol out of a byte, indexed in emission order.
module symbol_pick #(
  parameter int DATA_W    = 8,
  parameter int SYM_W     = 4,
  parameter bit LSB_FIRST = 1'b1,
  parameter int SEL_W     = 1
) (
  input  logic [DATA_W-1:0] sr,
  input  logic [SEL_W-1:0]  cnt,
  output logic [SYM_W-1:0]  sym
);

  localparam int N = DATA_W / SYM_W;

  logic [SYM_W-1:0] syms [N];

  for (genvar gi = 0; gi < N; gi++) begin : gSym
    if (LSB_FIRST) begin : gLsb
      assign syms[gi] = sr[gi*SYM_W +: SYM_W];
    end else begin : gMsb
      assign syms[gi] = sr[(N-1-gi)*SYM_W +: SYM_W];
    end
  end

  // Explicit compare loop keeps the index legal even when N is 1 or not a power of two.
  always_comb begin
    sym = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(cnt) == i) sym = syms[i];
    end
  end

endmodule

// File: rtl/symbol_serializer.sv
// Byte-to-symbol serializer with a one-byte hold register for bubble-free streaming.
// Optional statistics counters are enabled with SYMBOL_SERIALIZER_STATS_EN.
module symbol_serializer
  import symser_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int SYM_W     = SYM_W_DEF,
  parameter bit LSB_FIRST = 1'b1,
  localparam int N        = symCount(DATA_W, SYM_W),
  localparam int SEL_W    = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              syncClear,
  input  logic [DATA_W-1:0] inData,
  input  logic              inLast,
  input  logic              inValid,
  output logic              inReady,
  output logic [SYM_W-1:0]  outData,
  output logic [SEL_W-1:0]  outSel,
  output logic              outLast,
  output logic              outValid,
  input  logic              outReady
`ifdef SYMBOL_SERIALIZER_STATS_EN
  ,
  output logic [15:0]       byteCount,
  output logic [15:0]       frameCount
`endif
);

  if (DATA_W % SYM_W != 0) begin : gBadParams
    $error("symbol_serializer: DATA_W (%0d) must be a multiple of SYM_W (%0d)", DATA_W, SYM_W);
  end

  localparam logic [SEL_W-1:0] LAST_IDX   = SEL_W'(N - 1);
  localparam serState_e        LOAD_STATE = (N == 1) ? LASTSYM : SHIFT;

  serState_e         stateReg, stateNext;
  logic [SEL_W-1:0]  cntReg, cntNext;
  logic [DATA_W-1:0] srReg, srNext, hrReg, hrNext;
  logic              srLastReg, srLastNext, hrLastReg, hrLastNext;
  logic              hrValidReg, hrValidNext;
  logic              inReadyReg;
  logic              inXfer, outXfer;

  assign inXfer  = inValid & inReadyReg;
  assign outXfer = outValid & outReady;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg   <= IDLE;
      cntReg     <= '0;
      srReg      <= '0;
      srLastReg  <= 1'b0;
      hrReg      <= '0;
      hrLastReg  <= 1'b0;
      hrValidReg <= 1'b0;
      inReadyReg <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      cntReg     <= cntNext;
      srReg      <= srNext;
      srLastReg  <= srLastNext;
      hrReg      <= hrNext;
      hrLastReg  <= hrLastNext;
      hrValidReg <= hrValidNext;
      inReadyReg <= !hrValidNext;
    end
  end

  // inReady only rises while HR is empty, so an input transfer never coincides with an HR drain.
  always_comb begin
    stateNext   = stateReg;
    cntNext     = cntReg;
    srNext      = srReg;
    srLastNext  = srLastReg;
    hrNext      = hrReg;
    hrLastNext  = hrLastReg;
    hrValidNext = hrValidReg;
    if (syncClear) begin
      stateNext   = IDLE;
      cntNext     = '0;
      srNext      = '0;
      srLastNext  = 1'b0;
      hrValidNext = 1'b0;
      hrLastNext  = 1'b0;
    end else begin
      unique case (stateReg)
        IDLE: begin
          if (inXfer) begin
            srNext     = inData;
            srLastNext = inLast;
            cntNext    = '0;
            stateNext  = LOAD_STATE;
          end
        end
        SHIFT: begin
          if (outXfer) begin
            cntNext = cntReg + 1'b1;
            if (cntNext == LAST_IDX) stateNext = LASTSYM;
          end
          if (inXfer) begin
            hrNext      = inData;
            hrLastNext  = inLast;
            hrValidNext = 1'b1;
          end
        end
        LASTSYM: begin
          if (outXfer) begin
            cntNext = '0;
            if (hrValidReg) begin
              srNext      = hrReg;
              srLastNext  = hrLastReg;
              hrValidNext = 1'b0;
              stateNext   = LOAD_STATE;
            end else if (inXfer) begin
              srNext     = inData;
              srLastNext = inLast;
              stateNext  = LOAD_STATE;
            end else begin
              stateNext = IDLE;
            end
          end else if (inXfer) begin
            hrNext      = inData;
            hrLastNext  = inLast;
            hrValidNext = 1'b1;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  symbol_pick #(
    .DATA_W   (DATA_W),
    .SYM_W    (SYM_W),
    .LSB_FIRST(LSB_FIRST),
    .SEL_W    (SEL_W)
  ) uPick (
    .sr (srReg),
    .cnt(cntReg),
    .sym(outData)
  );

  assign inReady  = inReadyReg;
  assign outValid = (stateReg != IDLE);
  assign outSel   = cntReg;
  assign outLast  = srLastReg & (cntReg == LAST_IDX);

`ifdef SYMBOL_SERIALIZER_STATS_EN
  logic [15:0] byteCountReg, frameCountReg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byteCountReg  <= '0;
      frameCountReg <= '0;
    end else if (syncClear) begin
      byteCountReg  <= '0;
      frameCountReg <= '0;
    end else begin
      if (outXfer && stateReg == LASTSYM && byteCountReg != 16'hFFFF)
        byteCountReg <= byteCountReg + 16'd1;
      if (outXfer && outLast && frameCountReg != 16'hFFFF)
        frameCountReg <= frameCountReg + 16'd1;
    end
  end

  assign byteCount  = byteCountReg;
  assign frameCount = frameCountReg;
`endif

endmodule

// File: tb/tb_symbol_serializer.sv
// Directed self-checking bench: default nibble serializer plus an MSB-first bit-serial instance.
module tb_symbol_serializer;

  logic       clk = 1'b0;
  logic       rst_n, syncClear;
  logic [7:0] inData;
  logic       inLast, inValid, inReady, outLast, outValid, outReady;
  logic [3:0] outData;
  logic [0:0] outSel;

  logic [7:0] bInData;
  logic       bInLast, bInValid, bInReady, bOutLast, bOutValid, bOutReady;
  logic [0:0] bOutData;
  logic [2:0] bOutSel;

`ifdef SYMBOL_SERIALIZER_STATS_EN
  logic [15:0] byteCount, frameCount, bByteCount, bFrameCount;
`endif

  int tests = 0;
  int failed = 0;
  int k, b;
  logic acc, started;
  logic [7:0] bitsExp;

  always #5 clk = ~clk;

  symbol_serializer dut (
    .clk(clk), .rst_n(rst_n), .syncClear(syncClear),
    .inData(inData), .inLast(inLast), .inValid(inValid), .inReady(inReady),
    .outData(outData), .outSel(outSel), .outLast(outLast), .outValid(outValid),
    .outReady(outReady)
`ifdef SYMBOL_SERIALIZER_STATS_EN
    , .byteCount(byteCount), .frameCount(frameCount)
`endif
  );

  symbol_serializer #(.DATA_W(8), .SYM_W(1), .LSB_FIRST(1'b0)) dutBit (
    .clk(clk), .rst_n(rst_n), .syncClear(1'b0),
    .inData(bInData), .inLast(bInLast), .inValid(bInValid), .inReady(bInReady),
    .outData(bOutData), .outSel(bOutSel), .outLast(bOutLast), .outValid(bOutValid),
    .outReady(bOutReady)
`ifdef SYMBOL_SERIALIZER_STATS_EN
    , .byteCount(bByteCount), .frameCount(bFrameCount)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; syncClear = 1'b0;
    inData = '0; inLast = 1'b0; inValid = 1'b0; outReady = 1'b0;
    bInData = '0; bInLast = 1'b0; bInValid = 1'b0; bOutReady = 1'b0;

    // Reset state
    step(); step();
    check("rst_inReady", 32'(inReady), 0);
    check("rst_outValid", 32'(outValid), 0);
    check("rst_outData", 32'(outData), 0);
    check("rst_outSel", 32'(outSel), 0);
    check("rst_outLast", 32'(outLast), 0);
    check("rst_bit_inReady", 32'(bInReady), 0);
    rst_n = 1'b1;
    step();
    check("post_rst_inReady", 32'(inReady), 1);
    check("post_rst_outValid", 32'(outValid), 0);
    $display("[TB] reset done");

    // Single byte A5 with inLast
    inData = 8'hA5; inLast = 1'b1; inValid = 1'b1; outReady = 1'b1;
    step();
    inValid = 1'b0; inLast = 1'b0;
    check("a5_s0_valid", 32'(outValid), 1);
    check("a5_s0_data", 32'(outData), 32'h5);
    check("a5_s0_sel", 32'(outSel), 0);
    check("a5_s0_last", 32'(outLast), 0);
    check("a5_s0_inReady", 32'(inReady), 1);
    step();
    check("a5_s1_data", 32'(outData), 32'hA);
    check("a5_s1_sel", 32'(outSel), 1);
    check("a5_s1_last", 32'(outLast), 1);
    check("a5_s1_inReady", 32'(inReady), 1);
    step();
    check("a5_idle_valid", 32'(outValid), 0);
    check("a5_idle_inReady", 32'(inReady), 1);
    $display("[TB] single byte A5 done");

    // Back-to-back stream 01..0F
    k = 0; b = 1; started = 1'b0;
    for (int c = 0; c < 40 && k < 30; c++) begin
      inValid = (b <= 15);
      inData  = 8'(b);
      acc     = inReady & inValid;
      step();
      if (acc) b++;
      if (started || outValid) begin
        started = 1'b1;
        check("stream_valid", 32'(outValid), 1);
        if (outValid) begin
          check("stream_data", 32'(outData), (k % 2 == 0) ? 32'(k / 2 + 1) : 32'h0);
          k++;
        end
      end
    end
    inValid = 1'b0;
    check("stream_count", 32'(k), 30);
    step();
    check("stream_end_valid", 32'(outValid), 0);
    $display("[TB] stream 01..0F done");

    // Backpressure mid-byte 3C, next byte 5A parks in HR
    inData = 8'h3C; inValid = 1'b1; outReady = 1'b0;
    step();
    inData = 8'h5A;
    check("bp_data0", 32'(outData), 32'hC);
    check("bp_inReady0", 32'(inReady), 1);
    step();
    inValid = 1'b0;
    check("bp_hr_inReady", 32'(inReady), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_hold_data", 32'(outData), 32'hC);
      check("bp_hold_sel", 32'(outSel), 0);
      check("bp_hold_inReady", 32'(inReady), 0);
    end
    outReady = 1'b1;
    step();
    check("bp_resume_data", 32'(outData), 32'h3);
    check("bp_resume_sel", 32'(outSel), 1);
    step();
    check("bp_hr_data", 32'(outData), 32'hA);
    check("bp_hr_sel", 32'(outSel), 0);
    check("bp_hr_free_inReady", 32'(inReady), 1);
    step();
    check("bp_hr_data1", 32'(outData), 32'h5);
    step();
    check("bp_end_valid", 32'(outValid), 0);
    $display("[TB] backpressure done");

    // syncClear during symbol 0 of 77 with HR holding 12
    inData = 8'h77; inValid = 1'b1; outReady = 1'b0;
    step();
    inData = 8'h12;
    step();
    inValid = 1'b0;
    check("sc_pre_inReady", 32'(inReady), 0);
    check("sc_pre_data", 32'(outData), 32'h7);
    syncClear = 1'b1; outReady = 1'b1;
    step();
    syncClear = 1'b0;
    check("sc_valid", 32'(outValid), 0);
    check("sc_inReady", 32'(inReady), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("sc_no_emit", 32'(outValid), 0);
    end
    $display("[TB] syncClear done");

`ifdef SYMBOL_SERIALIZER_STATS_EN
    // Three frames of two bytes each
    check("stats_clr_bytes", 32'(byteCount), 0);
    b = 1;
    for (int c = 0; c < 30 && b <= 6; c++) begin
      inValid = 1'b1;
      inData  = 8'(b);
      inLast  = (b % 2 == 0);
      acc     = inReady;
      step();
      if (acc) b++;
    end
    inValid = 1'b0; inLast = 1'b0;
    repeat (4) step();
    check("stats_bytes", 32'(byteCount), 6);
    check("stats_frames", 32'(frameCount), 3);
    $display("[TB] stats done");
`endif

    // Bit-serial MSB-first 1000_0001
    bitsExp = 8'b1000_0001;
    bInData = bitsExp; bInLast = 1'b1; bInValid = 1'b1; bOutReady = 1'b1;
    step();
    bInValid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("bit_valid", 32'(bOutValid), 1);
      check("bit_data", 32'(bOutData), 32'(bitsExp[7-i]));
      check("bit_sel", 32'(bOutSel), 32'(i));
      check("bit_last", 32'(bOutLast), (i == 7) ? 32'd1 : 32'd0);
      step();
    end
    check("bit_end_valid", 32'(bOutValid), 0);
    $display("[TB] bit-serial done");

    // Asynchronous reset mid-byte
    inData = 8'h96; inValid = 1'b1; outReady = 1'b0;
    step();
    inValid = 1'b0;
    check("ar_pre_valid", 32'(outValid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(outValid), 0);
    check("ar_data", 32'(outData), 0);
    check("ar_inReady", 32'(inReady), 0);
    rst_n = 1'b1;
    step();
    check("ar_rel_inReady", 32'(inReady), 1);
    check("ar_rel_valid", 32'(outValid), 0);
    $display("[TB] async reset done");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
